// File: rtl/aud_dsp.sv
// Playback sample engine: fetches signed 16-bit samples from SRAM and emits one per LRCK frame,
// with fast (skip) and slow (hold/interpolate) playback. Optional macro: AUD_DSP_LINEAR_INTERP_EN.
module aud_dsp #(
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_pause,
  input  logic                     i_stop,
  input  logic                     i_fast,
  input  logic [2:0]               i_speed,
  input  logic                     i_interp,
  input  logic [ADDR_W-1:0]        i_end_addr,
  input  logic                     i_daclrck,
  input  logic signed [15:0]       i_sram_data,
  output logic [ADDR_W-1:0]        o_sram_addr,
  output logic signed [15:0]       o_dac_data,
  output logic                     o_en,
  output logic                     o_done,
  output logic [1:0]               o_dbg_state
);

  // SRAM side has no handshake: the address is held for RD_LAT+1 cycles and data is taken on
  // the last of them; the serializer consumes o_dac_data whenever o_en is high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [1:0] LAT_LAST = RD_LAT[1:0];

  state_t                state;
  logic                  lrck_d;
  logic                  fe;
  logic [2:0]            k;
  logic [2:0]            n_lat;
  logic                  fast_lat;
  logic [1:0]            lat_cnt;
  logic                  pause_pend;
  logic signed [15:0]    cur;
  logic signed [15:0]    out_val;
  logic [2:0]            speed_n;
  logic [ADDR_W:0]       next_addr;
  logic                  group_end;
  logic                  past_end;

  assign fe          = lrck_d & ~i_daclrck;
  assign speed_n     = (i_speed == 3'd0) ? 3'd1 : i_speed;
  assign o_dbg_state = state;

  // One extra address bit so the end-of-recording compare never wraps.
  always_comb begin
    group_end = fast_lat || (k == (n_lat - 3'd1));
    if (fast_lat) next_addr = {1'b0, o_sram_addr} + {{(ADDR_W-2){1'b0}}, n_lat};
    else          next_addr = {1'b0, o_sram_addr} + {{ADDR_W{1'b0}}, 1'b1};
    past_end  = next_addr > {1'b0, i_end_addr};
  end

`ifdef AUD_DSP_LINEAR_INTERP_EN
  logic                  interp_lat;
  logic signed [15:0]    prev;
  logic signed [18:0]    prev_x;
  logic signed [18:0]    cur_x;
  logic signed [18:0]    w_prev;
  logic signed [18:0]    w_cur;
  logic signed [18:0]    interp_num;
  logic signed [18:0]    interp_den;
  logic signed [15:0]    interp_q;

  // Weighted blend of the previous and current sample; signed divide truncates toward zero.
  always_comb begin
    prev_x     = {{3{prev[15]}}, prev};
    cur_x      = {{3{cur[15]}}, cur};
    w_prev     = {16'd0, n_lat - k};
    w_cur      = {16'd0, k};
    interp_den = {16'd0, n_lat};
    interp_num = prev_x * w_prev + cur_x * w_cur;
    interp_q   = 16'(interp_num / interp_den);
    if (interp_lat && !fast_lat && (n_lat != 3'd1)) out_val = interp_q;
    else                                           out_val = cur;
  end
`else
  logic unused_interp;
  assign unused_interp = i_interp;

  always_comb begin
    out_val = cur;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      lrck_d      <= 1'b0;
      o_sram_addr <= '0;
      o_dac_data  <= '0;
      o_en        <= 1'b0;
      o_done      <= 1'b0;
      k           <= 3'd0;
      n_lat       <= 3'd1;
      fast_lat    <= 1'b0;
      lat_cnt     <= 2'd0;
      pause_pend  <= 1'b0;
      cur         <= '0;
`ifdef AUD_DSP_LINEAR_INTERP_EN
      prev        <= '0;
      interp_lat  <= 1'b0;
`endif
    end else begin
      lrck_d <= i_daclrck;
      o_done <= 1'b0;
      if (i_stop) begin
        state       <= S_IDLE;
        o_en        <= 1'b0;
        o_dac_data  <= '0;
        o_sram_addr <= '0;
        k           <= 3'd0;
        pause_pend  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // A finished recording keeps its last sample audible until the next frame.
            if (fe) begin
              o_en       <= 1'b0;
              o_dac_data <= '0;
            end
            if (i_start) begin
              state       <= S_FETCH;
              o_sram_addr <= '0;
              o_en        <= 1'b0;
              o_dac_data  <= '0;
              k           <= 3'd0;
              lat_cnt     <= 2'd0;
              pause_pend  <= 1'b0;
              cur         <= '0;
              n_lat       <= speed_n;
              fast_lat    <= i_fast;
`ifdef AUD_DSP_LINEAR_INTERP_EN
              prev        <= '0;
              interp_lat  <= i_interp;
`endif
            end
          end
          S_FETCH: begin
            if (i_pause) pause_pend <= 1'b1;
            if (lat_cnt == LAT_LAST) begin
              cur        <= i_sram_data;
`ifdef AUD_DSP_LINEAR_INTERP_EN
              prev       <= cur;
`endif
              pause_pend <= 1'b0;
              if (pause_pend || i_pause) begin
                state <= S_PAUSE;
                o_en  <= 1'b0;
              end else begin
                state <= S_READY;
              end
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_READY: begin
            if (i_pause) begin
              state <= S_PAUSE;
              o_en  <= 1'b0;
            end else if (fe) begin
              o_dac_data <= out_val;
              o_en       <= 1'b1;
              if (group_end) begin
                k <= 3'd0;
                if (past_end) begin
                  state       <= S_IDLE;
                  o_done      <= 1'b1;
                  o_sram_addr <= '0;
                end else begin
                  // Mode and factor only change at a group boundary.
                  state       <= S_FETCH;
                  o_sram_addr <= next_addr[ADDR_W-1:0];
                  lat_cnt     <= 2'd0;
                  n_lat       <= speed_n;
                  fast_lat    <= i_fast;
`ifdef AUD_DSP_LINEAR_INTERP_EN
                  interp_lat  <= i_interp;
`endif
                end
              end else begin
                k <= k + 3'd1;
              end
            end
          end
          S_PAUSE: begin
            if (i_start && !i_pause) state <= S_READY;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_dsp.sv
// Self-checking bench for aud_dsp: directed playback scenarios plus randomized ones,
// checked against a sample-sequence reference model built from the playback rules.
module tb_aud_dsp;
  localparam int ADDR_W     = 20;
  localparam int RD_LAT     = 2;
  localparam int FRAME_HALF = 16;
`ifdef AUD_DSP_LINEAR_INTERP_EN
  localparam bit INTERP_ON = 1'b1;
`else
  localparam bit INTERP_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     pause;
  logic                     stop;
  logic                     fast;
  logic [2:0]               speed;
  logic                     interp;
  logic [ADDR_W-1:0]        end_addr;
  logic                     daclrck;
  logic signed [15:0]       sram_data;
  logic [ADDR_W-1:0]        sram_addr;
  logic signed [15:0]       dac_data;
  logic                     en;
  logic                     done;
  logic [1:0]               dbg_state;

  logic signed [15:0]       mem [0:63];
  logic [ADDR_W-1:0]        addr_d;
  logic [15:0]              exp_q[$];
  int                       n_checks = 0;
  int                       n_fail = 0;
  int                       done_cnt = 0;

  aud_dsp #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_fast      (fast),
    .i_speed     (speed),
    .i_interp    (interp),
    .i_end_addr  (end_addr),
    .i_daclrck   (daclrck),
    .i_sram_data (sram_data),
    .o_sram_addr (sram_addr),
    .o_dac_data  (dac_data),
    .o_en        (en),
    .o_done      (done),
    .o_dbg_state (dbg_state)
  );

  // clock / SRAM model (data valid RD_LAT=2 cycles after the address changes) / done monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    addr_d    <= sram_addr;
    sram_data <= mem[addr_d[5:0]];
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: the full list of samples the serializer should receive, in order.
  task automatic build_exp(input int n_in, input bit fst, input bit itp, input int end_a);
    int n;
    int p;
    int c;
    n = (n_in == 0) ? 1 : n_in;
    exp_q.delete();
    if (fst) begin
      for (int a = 0; a <= end_a; a += n) exp_q.push_back(16'(mem[a]));
    end else begin
      p = 0;
      for (int a = 0; a <= end_a; a++) begin
        c = mem[a];
        for (int j = 0; j < n; j++) begin
          if (itp && n > 1) exp_q.push_back(16'((p * (n - j) + c * j) / n));
          else              exp_q.push_back(16'(c));
        end
        p = c;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // One LRCK frame; optionally checks the sample presented right after the frame edge.
  task automatic frame(input bit chk, input string tag);
    logic [15:0] exp;
    @(negedge clk) daclrck = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      exp = exp_q.pop_front();
      check({tag, "_en"}, en, 1);
      check({tag, "_data"}, $unsigned(dac_data), exp);
    end
    repeat (FRAME_HALF - 2) @(negedge clk);
    daclrck = 1'b1;
    repeat (FRAME_HALF) @(negedge clk);
  endtask

  task automatic run_play(input string tag, input int n, input bit fst, input bit itp, input int end_a);
    int d0;
    speed    = n[2:0];
    fast     = fst;
    interp   = itp;
    end_addr = end_a[ADDR_W-1:0];
    build_exp(n, fst, itp && INTERP_ON, end_a);
    d0 = done_cnt;
    pulse_start();
    repeat (8) @(negedge clk);
    check({tag, "_en_pre"}, en, 0);
    while (exp_q.size() > 0) frame(1, tag);
    check({tag, "_done"}, done_cnt - d0, 1);
    frame(0, tag);
    check({tag, "_en_post"}, en, 0);
    check({tag, "_data_post"}, $unsigned(dac_data), 0);
    check({tag, "_addr_post"}, sram_addr, 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; fast = 1'b0;
    speed = 3'd1; interp = 1'b0; end_addr = '0; daclrck = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_en", en, 0);
    check("rst_data", $unsigned(dac_data), 0);
    check("rst_addr", sram_addr, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // reset while playing
    fill_ramp();
    speed = 3'd1; fast = 1'b0; end_addr = 20'd7;
    build_exp(1, 0, 0, 7);
    d0 = done_cnt;
    pulse_start();
    repeat (8) @(negedge clk);
    repeat (2) frame(1, "prerst");
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("midrst_en", en, 0);
    check("midrst_data", $unsigned(dac_data), 0);
    check("midrst_addr", sram_addr, 0);
    check("midrst_state", dbg_state, 0);
    frame(0, "postrst");
    check("midrst_nodone", done_cnt - d0, 0);
    exp_q.delete();

    // directed playback scenarios
    fill_ramp();
    run_play("norm", 1, 0, 0, 7);
    run_play("fast3", 3, 1, 0, 9);
    mem[0] = 16'sd100; mem[1] = -16'sd100;
    run_play("hold4", 4, 0, 0, 1);
    run_play("interp4", 4, 0, 1, 1);
    run_play("speed0", 0, 0, 0, 2);

    // pause after the third sample, resume, then stop and start together
    fill_ramp();
    speed = 3'd1; fast = 1'b0; interp = 1'b0; end_addr = 20'd7;
    build_exp(1, 0, 0, 7);
    d0 = done_cnt;
    pulse_start();
    repeat (8) @(negedge clk);
    repeat (3) frame(1, "pause_pre");
    pause = 1'b1;
    @(negedge clk) pause = 1'b0;
    for (int f = 0; f < 5; f++) begin
      frame(0, "pause");
      check("pause_en", en, 0);
      check("pause_hold", $unsigned(dac_data), 32);
    end
    pulse_start();
    while (exp_q.size() > 0) frame(1, "pause_post");
    check("pause_done", done_cnt - d0, 1);
    frame(0, "pause_end");

    build_exp(1, 0, 0, 7);
    pulse_start();
    repeat (8) @(negedge clk);
    repeat (2) frame(1, "ss_pre");
    @(negedge clk) begin stop = 1'b1; start = 1'b1; end
    @(negedge clk) begin stop = 1'b0; start = 1'b0; end
    check("ss_state", dbg_state, 0);
    check("ss_addr", sram_addr, 0);
    check("ss_en", en, 0);
    check("ss_data", $unsigned(dac_data), 0);
    frame(0, "ss_idle");
    check("ss_still_idle", dbg_state, 0);
    exp_q.delete();

    // randomized scenarios
    for (int t = 0; t < 10; t++) begin
      int n_r;
      int f_r;
      int i_r;
      int e_r;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      n_r = $urandom_range(0, 7);
      f_r = $urandom_range(0, 1);
      i_r = $urandom_range(0, 1);
      e_r = (f_r != 0) ? $urandom_range(0, 20) : $urandom_range(0, 5);
      run_play($sformatf("rnd%0d", t), n_r, f_r[0], i_r[0], e_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
